// File: rtl/avg_pkg.sv
// Shared definitions for the valid-gated averager family.
// Holds the FSM state type, the accumulator-width rule and the
// window-exponent clamp used by every decimator built on avg_shift_round.
package avg_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } avgState_t;

  // Summing 2^maxLog2 full-scale samples needs maxLog2 extra bits of headroom
  function automatic int calcAccWidth(input int dataWidth, input int maxLog2);
    return dataWidth + maxLog2;
  endfunction

  // Exponents beyond what the accumulator can hold collapse to the largest window
  function automatic int clamp_log2(input int value, input int maxLog2);
    return (value > maxLog2) ? maxLog2 : value;
  endfunction

endpackage

// File: rtl/avg_shift_round.sv
// Divides a signed window sum by 2^shift and truncates to the output width.
// Build option AVG_ROUND_EN: when defined, adds half an LSB of the quotient
// before the arithmetic shift (round half up); otherwise the shift floors
// toward minus infinity. Purely combinational.
module avg_shift_round #(
  parameter int DATA_WIDTH  = 16,
  parameter int ACC_WIDTH   = 26,
  parameter int SHIFT_WIDTH = 4
) (
  input  logic signed [ACC_WIDTH-1:0]   sum,
  input  logic        [SHIFT_WIDTH-1:0] shift,
  output logic signed [DATA_WIDTH-1:0]  mean
);

  logic signed [ACC_WIDTH-1:0] rounded;

`ifdef AVG_ROUND_EN
  logic signed [ACC_WIDTH-1:0] bias;

  // Half of the divisor, or nothing when the window is a single sample
  always_comb begin
    bias = '0;
    if (shift != '0) begin
      bias = ACC_WIDTH'(1) << (shift - SHIFT_WIDTH'(1));
    end
  end

  assign rounded = sum + bias;
`else
  assign rounded = sum;
`endif

  // The mean of in-range samples always fits the output width, so plain truncation is safe
  assign mean = DATA_WIDTH'(rounded >>> shift);

endmodule

// File: rtl/valid_gated_averager.sv
// Averages signed samples over windows of 2^log2Samples qualified samples.
// Samples count only while dataValidIn is high; a valid drop, a reset or a
// change of the window exponent mid-window throws the partial window away.
// Build option AVG_ROUND_EN selects round-half-up instead of floor division
// (handled inside avg_shift_round).
module valid_gated_averager
  import avg_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_LOG2   = 10
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic signed [DATA_WIDTH-1:0]         dataIn,
  input  logic                                 dataValidIn,
  input  logic        [$clog2(MAX_LOG2+1)-1:0] log2Samples,
  output logic signed [DATA_WIDTH-1:0]         avgOut,
  output logic                                 avgStrobe,
  output logic                                 dataValid
);

  localparam int ACC_WIDTH  = calcAccWidth(DATA_WIDTH, MAX_LOG2);
  localparam int LOG2_WIDTH = $clog2(MAX_LOG2 + 1);

  avgState_t                   state;
  logic signed [ACC_WIDTH-1:0] acc;
  logic        [MAX_LOG2-1:0]  cnt;
  logic        [LOG2_WIDTH-1:0] cfgLog2;

  logic        [LOG2_WIDTH-1:0] liveLog2;
  logic        [LOG2_WIDTH-1:0] curLog2;
  logic signed [ACC_WIDTH-1:0]  dataExt;
  logic signed [ACC_WIDTH-1:0]  accNext;
  logic        [MAX_LOG2:0]     windowSize;
  logic                         windowEnd;
  logic                         cfgChanged;
  logic signed [DATA_WIDTH-1:0] mean;

  assign liveLog2 = LOG2_WIDTH'(clamp_log2(int'(log2Samples), MAX_LOG2));

  // A window opening from IDLE takes the live exponent; an open window keeps its registered one
  assign curLog2    = (state == IDLE) ? liveLog2 : cfgLog2;
  assign cfgChanged = (state == ACCUM) && (liveLog2 != cfgLog2);

  assign dataExt    = {{(ACC_WIDTH - DATA_WIDTH){dataIn[DATA_WIDTH-1]}}, dataIn};
  assign accNext    = acc + dataExt;
  assign windowSize = (MAX_LOG2 + 1)'(1) << curLog2;
  assign windowEnd  = ({1'b0, cnt} == (windowSize - (MAX_LOG2 + 1)'(1)));

  avg_shift_round #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .SHIFT_WIDTH(LOG2_WIDTH)
  ) shiftRound (
    .sum  (accNext),
    .shift(curLog2),
    .mean (mean)
  );

  // Window FSM: gate on valid, abort on exponent change, emit the mean when the window fills
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      cfgLog2   <= '0;
      avgOut    <= '0;
      avgStrobe <= 1'b0;
      dataValid <= 1'b0;
    end else begin
      avgStrobe <= 1'b0;
      if (!dataValidIn) begin
        state     <= IDLE;
        acc       <= '0;
        cnt       <= '0;
        cfgLog2   <= liveLog2;
        dataValid <= 1'b0;
      end else if (cfgChanged) begin
        acc     <= '0;
        cnt     <= '0;
        cfgLog2 <= liveLog2;
      end else begin
        state   <= ACCUM;
        cfgLog2 <= liveLog2;
        if (windowEnd) begin
          avgOut    <= mean;
          avgStrobe <= 1'b1;
          dataValid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= accNext;
          cnt <= cnt + MAX_LOG2'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_valid_gated_averager.sv
// Self-checking bench for valid_gated_averager.
// A queue-based window model predicts the outputs every cycle; directed
// literal checks pin the model on the documented scenarios. Expected
// rounding results follow the AVG_ROUND_EN build option.
module tb_valid_gated_averager;

  localparam int DATA_WIDTH = 16;
  localparam int MAX_LOG2   = 10;
  localparam int LOG2_WIDTH = $clog2(MAX_LOG2 + 1);

  logic                         clk = 1'b0;
  logic                         reset;
  logic signed [DATA_WIDTH-1:0] dataIn;
  logic                         dataValidIn;
  logic        [LOG2_WIDTH-1:0] log2Samples;
  logic signed [DATA_WIDTH-1:0] avgOut;
  logic                         avgStrobe;
  logic                         dataValid;

  int vectors    = 0;
  int miscompares = 0;
  bit checking   = 1'b0;

  // Model state
  int mdlAvg    = 0;
  bit mdlStrobe = 1'b0;
  bit mdlDv     = 1'b0;
  int mdlCfg    = 0;
  bit mdlActive = 1'b0;
  int window[$];

  valid_gated_averager #(
    .DATA_WIDTH(DATA_WIDTH),
    .MAX_LOG2  (MAX_LOG2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .dataIn     (dataIn),
    .dataValidIn(dataValidIn),
    .log2Samples(log2Samples),
    .avgOut     (avgOut),
    .avgStrobe  (avgStrobe),
    .dataValid  (dataValid)
  );

  always #5 clk = ~clk;

  // Mean of the collected window by plain integer division, floored or rounded half up
  function automatic int windowMean(input int log2n);
    longint sum = 0;
    longint n   = longint'(1) << log2n;
    longint q;
    foreach (window[i]) sum += window[i];
`ifdef AVG_ROUND_EN
    if (log2n > 0) sum += n / 2;
`endif
    q = sum / n;
    if ((sum % n) != 0 && sum < 0) q -= 1;
    return int'(q);
  endfunction

  // Behavioural model: evaluates the window rules on each rising edge
  initial begin
    int eff;
    forever begin
      @(posedge clk);
      mdlStrobe = 1'b0;
      if (reset) begin
        window.delete();
        mdlAvg    = 0;
        mdlDv     = 1'b0;
        mdlActive = 1'b0;
        mdlCfg    = 0;
      end else if (!dataValidIn) begin
        window.delete();
        mdlDv     = 1'b0;
        mdlActive = 1'b0;
      end else begin
        eff = (int'(log2Samples) > MAX_LOG2) ? MAX_LOG2 : int'(log2Samples);
        if (mdlActive && eff != mdlCfg) begin
          window.delete();
          mdlCfg = eff;
        end else begin
          mdlCfg = eff;
          window.push_back(int'(dataIn));
          if (window.size() == (1 << mdlCfg)) begin
            mdlAvg    = windowMean(mdlCfg);
            mdlStrobe = 1'b1;
            mdlDv     = 1'b1;
            window.delete();
          end
        end
        mdlActive = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (checking) begin
      vectors++;
      if (int'(avgOut) != mdlAvg || avgStrobe !== mdlStrobe || dataValid !== mdlDv) begin
        miscompares++;
        $display("[TB] FAIL model t=%0t: avgOut=%0d avgStrobe=%0b dataValid=%0b, expected %0d %0b %0b",
                 $time, avgOut, avgStrobe, dataValid, mdlAvg, mdlStrobe, mdlDv);
      end
    end
  end

  // Drive one cycle of inputs and return after the outputs of that edge have settled
  task automatic applyStimulus(input bit rst, input bit valid, input int data, input int log2n);
    reset       = rst;
    dataValidIn = valid;
    dataIn      = data[DATA_WIDTH-1:0];
    log2Samples = log2n[LOG2_WIDTH-1:0];
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int expAvg, input bit expStrobe, input bit expDv);
    vectors++;
    if (int'(avgOut) != expAvg || avgStrobe !== expStrobe || dataValid !== expDv) begin
      miscompares++;
      $display("[TB] FAIL %s: avgOut=%0d avgStrobe=%0b dataValid=%0b, expected %0d %0b %0b",
               name, avgOut, avgStrobe, dataValid, expAvg, expStrobe, expDv);
    end
  endtask

  initial begin
    int roundExp;
    int avg8Exp;
    reset       = 1'b1;
    dataValidIn = 1'b0;
    dataIn      = '0;
    log2Samples = '0;

`ifdef AVG_ROUND_EN
    roundExp = -1;
    avg8Exp  = 5;
`else
    roundExp = -2;
    avg8Exp  = 4;
`endif

    applyStimulus(1, 0, 0, 2);
    applyStimulus(1, 0, 0, 2);
    checking = 1'b1;
    checkOutput("resetState", 0, 0, 0);

    // Four-sample windows back to back
    applyStimulus(0, 1, 10, 2);
    applyStimulus(0, 1, 20, 2);
    applyStimulus(0, 1, 30, 2);
    checkOutput("noEarlyStrobe", 0, 0, 0);
    applyStimulus(0, 1, 40, 2);
    checkOutput("avg4", 25, 1, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, -4, 2);
    checkOutput("holdBetween", 25, 0, 1);
    applyStimulus(0, 1, -4, 2);
    checkOutput("avgNeg", -4, 1, 1);
    applyStimulus(0, 0, 0, 3);
    checkOutput("dropClears", -4, 0, 0);

    // Partial window dropped, then a fresh eight-sample window
    for (int i = 1; i <= 5; i++) applyStimulus(0, 1, i, 3);
    applyStimulus(0, 0, 0, 3);
    for (int i = 1; i <= 7; i++) applyStimulus(0, 1, i, 3);
    checkOutput("partialDiscarded", -4, 0, 0);
    applyStimulus(0, 1, 8, 3);
    checkOutput("avg8", avg8Exp, 1, 1);
    applyStimulus(0, 0, 0, 0);

    // Single-sample windows pass data straight through
    applyStimulus(0, 1, 5, 0);
    checkOutput("pass5", 5, 1, 1);
    applyStimulus(0, 1, -7, 0);
    checkOutput("passNeg7", -7, 1, 1);
    applyStimulus(0, 1, 100, 0);
    checkOutput("pass100", 100, 1, 1);
    applyStimulus(0, 0, 0, 1);

    // Rounding of a negative half
    applyStimulus(0, 1, -1, 1);
    applyStimulus(0, 1, -2, 1);
    checkOutput("roundNeg", roundExp, 1, 1);

    // Exponent change on an open window aborts it without touching dataValid
    applyStimulus(0, 1, 1, 2);
    checkOutput("cfgAbort", roundExp, 0, 1);
    applyStimulus(0, 1, 2, 2);
    applyStimulus(0, 1, 4, 2);
    applyStimulus(0, 1, 6, 2);
    checkOutput("afterAbortPartial", roundExp, 0, 1);
    applyStimulus(0, 1, 8, 2);
    checkOutput("afterAbortFull", 5, 1, 1);

    // Reset on the window-closing sample wins
    applyStimulus(0, 1, 1, 2);
    applyStimulus(0, 1, 1, 2);
    applyStimulus(0, 1, 1, 2);
    applyStimulus(1, 1, 1, 2);
    checkOutput("resetAtWindowEnd", 0, 0, 0);
    applyStimulus(0, 0, 0, 10);

    // Full-scale windows, the second with an out-of-range exponent that clamps
    for (int i = 0; i < 1024; i++) applyStimulus(0, 1, -32768, 10);
    checkOutput("fullScaleNeg", -32768, 1, 1);
    for (int i = 0; i < 1024; i++) applyStimulus(0, 1, 32767, 15);
    checkOutput("fullScalePos", 32767, 1, 1);

    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checking = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
